// File: rtl/dm_spi_pkg.sv
// rtl/dm_spi_pkg.sv - CoreSPI register map, STATUS bits, defaults and FSM state types (optional DM_SPI_SEQ_RXDRAIN_EN adds drain states)
package dm_spi_pkg;

  localparam int APB_AW_DEF = 7;
  localparam int APB_DW_DEF = 16;

  localparam logic [6:0] REG_CONTROL     = 7'h00;
  localparam logic [6:0] REG_RXDATA      = 7'h08;
  localparam logic [6:0] REG_TXDATA      = 7'h0C;
  localparam logic [6:0] REG_STATUS      = 7'h20;
  localparam logic [6:0] REG_SSEL        = 7'h24;
  localparam logic [6:0] REG_TXDATA_LAST = 7'h28;

  localparam int STAT_RXEMPTY_BIT = 2;
  localparam int STAT_TXFULL_BIT  = 3;

  localparam logic [15:0] CTRL_INIT_DEF = 16'h0003;
  localparam logic [15:0] SSEL_INIT_DEF = 16'h0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_CTRL,
    S_INIT_SSEL,
    S_READY,
    S_POLL,
    S_WRITE
`ifdef DM_SPI_SEQ_RXDRAIN_EN
    ,
    S_DRAIN_STAT,
    S_DRAIN_RX
`endif
  } seq_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_ACCESS
  } xfer_state_t;

endpackage

// File: rtl/dm_spi_apb_sequencer_if.sv
// rtl/dm_spi_apb_sequencer_if.sv - upstream word stream plus APB master bus toward CoreSPI
interface dm_spi_apb_sequencer_if #(
  parameter int AW = dm_spi_pkg::APB_AW_DEF,
  parameter int DW = dm_spi_pkg::APB_DW_DEF
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;

  logic [AW-1:0] M_PADDR;
  logic          M_PSEL;
  logic          M_PENABLE;
  logic          M_PWRITE;
  logic [DW-1:0] M_PWDATA;
  logic [DW-1:0] M_PRDATA;
  logic          M_PREADY;
  logic          M_PSLVERR;

  modport master (
    input  s_valid, s_data, s_last, M_PRDATA, M_PREADY, M_PSLVERR,
    output s_ready, M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA
  );

  modport slave (
    output s_valid, s_data, s_last, M_PRDATA, M_PREADY, M_PSLVERR,
    input  s_ready, M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA
  );
endinterface

// File: rtl/dm_apb_master_xfer.sv
// rtl/dm_apb_master_xfer.sv - single two-phase APB transfer engine with done/rdata/slverr response
module dm_apb_master_xfer
  import dm_spi_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          write,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          slverr,
  output logic [AW-1:0] paddr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  xfer_state_t state, nxt;

  // Phase register; async reset drops PSEL/PENABLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= X_IDLE;
    else        state <= nxt;
  end

  // Phase sequencing: SETUP always one cycle, ACCESS held until PREADY.
  always_comb begin
    nxt = state;
    case (state)
      X_IDLE:   if (req) nxt = X_SETUP;
      X_SETUP:  nxt = X_ACCESS;
      X_ACCESS: if (pready) nxt = X_IDLE;
      default:  nxt = X_IDLE;
    endcase
  end

  assign psel    = (state != X_IDLE);
  assign penable = (state == X_ACCESS);

  // Capture the command at launch so the bus stays stable; return response on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      slverr <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == X_IDLE && req) begin
        paddr  <= addr;
        pwdata <= wdata;
        pwrite <= write;
      end
      if (state == X_ACCESS && pready) begin
        done   <= 1'b1;
        rdata  <= prdata;
        slverr <= pslverr;
      end
    end
  end

endmodule

// File: rtl/dm_spi_apb_sequencer.sv
// rtl/dm_spi_apb_sequencer.sv - CoreSPI init plus per-word STATUS poll and TXDATA write sequencer (DM_SPI_SEQ_RXDRAIN_EN enables RX drain)
module dm_spi_apb_sequencer
  import dm_spi_pkg::*;
#(
  parameter int              APB_AW     = 7,
  parameter int              APB_DW     = 16,
  parameter logic [APB_DW-1:0] CTRL_INIT  = CTRL_INIT_DEF,
  parameter logic [APB_DW-1:0] SSEL_INIT  = SSEL_INIT_DEF,
  parameter int              TXFULL_BIT = STAT_TXFULL_BIT,
  parameter int              POLL_LIMIT = 1023
) (
  input  logic                   PCLK,
  input  logic                   PRESETN,
  input  logic                   init_start,
  dm_spi_apb_sequencer_if.master bus,
  output logic                   init_done,
  output logic                   busy,
  output logic                   err_slv,
  output logic                   err_timeout,
  output logic [15:0]            frames_sent
);

  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_LIMIT - 1);

  seq_state_t        state, nxt;
  logic              pend;
  logic [APB_DW-1:0] word;
  logic              word_last;
  logic [CW-1:0]     poll_cnt;

  logic              req, cmd_write, done, slverr;
  logic [APB_AW-1:0] cmd_addr;
  logic [APB_DW-1:0] cmd_wdata, rdata;
  logic              accept, hit_timeout, frame_done, init_fin, cnt_clr, cnt_inc;
  logic              unused_rdata;

  // Only the status flag bits of a read are of interest.
  assign unused_rdata = ^rdata;

  dm_apb_master_xfer #(.AW(APB_AW), .DW(APB_DW)) u_xfer (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .req     (req),
    .addr    (cmd_addr),
    .wdata   (cmd_wdata),
    .write   (cmd_write),
    .done    (done),
    .rdata   (rdata),
    .slverr  (slverr),
    .paddr   (bus.M_PADDR),
    .psel    (bus.M_PSEL),
    .penable (bus.M_PENABLE),
    .pwrite  (bus.M_PWRITE),
    .pwdata  (bus.M_PWDATA),
    .prdata  (bus.M_PRDATA),
    .pready  (bus.M_PREADY),
    .pslverr (bus.M_PSLVERR)
  );

  assign bus.s_ready = (state == S_READY);
  assign busy        = (state != S_IDLE) && (state != S_READY);

  // Sequencer state register.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state <= S_IDLE;
    else          state <= nxt;
  end

  // Each command state issues exactly one transfer (req gated by pend) and advances on done.
  always_comb begin
    nxt         = state;
    req         = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    cmd_write   = 1'b0;
    accept      = 1'b0;
    hit_timeout = 1'b0;
    frame_done  = 1'b0;
    init_fin    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      S_IDLE: if (init_start) nxt = S_INIT_CTRL;
      S_INIT_CTRL: begin
        req       = !pend;
        cmd_addr  = REG_CONTROL;
        cmd_wdata = CTRL_INIT;
        cmd_write = 1'b1;
        if (done) nxt = S_INIT_SSEL;
      end
      S_INIT_SSEL: begin
        req       = !pend;
        cmd_addr  = REG_SSEL;
        cmd_wdata = SSEL_INIT;
        cmd_write = 1'b1;
        if (done) begin
          init_fin = 1'b1;
          nxt      = S_READY;
        end
      end
      S_READY: begin
        if (bus.s_valid) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          nxt     = S_POLL;
        end
      end
      S_POLL: begin
        req      = !pend;
        cmd_addr = REG_STATUS;
        if (done) begin
          if (!rdata[TXFULL_BIT]) begin
            nxt = S_WRITE;
          end else if (poll_cnt == POLL_LAST) begin
            hit_timeout = 1'b1;
            nxt         = S_READY;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_WRITE: begin
        req       = !pend;
        cmd_addr  = word_last ? REG_TXDATA_LAST : REG_TXDATA;
        cmd_wdata = word;
        cmd_write = 1'b1;
        if (done) begin
          frame_done = word_last;
`ifdef DM_SPI_SEQ_RXDRAIN_EN
          if (word_last) begin
            cnt_clr = 1'b1;
            nxt     = S_DRAIN_STAT;
          end else begin
            nxt = S_READY;
          end
`else
          nxt = S_READY;
`endif
        end
      end
`ifdef DM_SPI_SEQ_RXDRAIN_EN
      S_DRAIN_STAT: begin
        req      = !pend;
        cmd_addr = REG_STATUS;
        if (done) begin
          if (rdata[STAT_RXEMPTY_BIT]) begin
            nxt = S_READY;
          end else if (poll_cnt == POLL_LAST) begin
            hit_timeout = 1'b1;
            nxt         = S_READY;
          end else begin
            cnt_inc = 1'b1;
            nxt     = S_DRAIN_RX;
          end
        end
      end
      S_DRAIN_RX: begin
        req      = !pend;
        cmd_addr = REG_RXDATA;
        if (done) begin
          if (poll_cnt == POLL_LAST) begin
            hit_timeout = 1'b1;
            nxt         = S_READY;
          end else begin
            cnt_inc = 1'b1;
            nxt     = S_DRAIN_STAT;
          end
        end
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // Word latch, read counter, sticky flags and frame counter.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      pend        <= 1'b0;
      word        <= '0;
      word_last   <= 1'b0;
      poll_cnt    <= '0;
      init_done   <= 1'b0;
      err_slv     <= 1'b0;
      err_timeout <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (req)       pend <= 1'b1;
      else if (done) pend <= 1'b0;
      if (accept) begin
        word      <= bus.s_data;
        word_last <= bus.s_last;
      end
      if (cnt_clr)      poll_cnt <= '0;
      else if (cnt_inc) poll_cnt <= poll_cnt + 1'b1;
      if (init_fin)        init_done   <= 1'b1;
      if (done && slverr)  err_slv     <= 1'b1;
      if (hit_timeout)     err_timeout <= 1'b1;
      if (frame_done)      frames_sent <= frames_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_dm_spi_apb_sequencer.sv
// tb/tb_dm_spi_apb_sequencer.sv - self-checking bench for dm_spi_apb_sequencer
module tb_dm_spi_apb_sequencer;
  import dm_spi_pkg::*;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [15:0] data;
  } xfer_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          n_full;
    logic [6:0]  exp_addr;
    logic [15:0] exp_frames;
  } vec_t;

  logic clk;
  logic rst_n;
  logic init_start;
  logic init_done, busy, err_slv, err_timeout;
  logic [15:0] frames_sent;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int xfer_cnt = 0;

  xfer_t       exp_q[$];
  logic [15:0] stat_q[$];
  logic [15:0] stat_default = 16'h0000;
  int          wait_cfg = 0;
  logic        slverr_arm = 1'b0;
  logic        sready_bad = 1'b0;
  logic        lat_arm = 1'b0;
  int          lat_setup = 0;

  logic        prev_psel;
  logic        unstable;
  int          wcnt;
  logic [6:0]  su_addr;
  logic [15:0] su_data;
  logic        su_wr;

  vec_t vecs[6];

  dm_spi_apb_sequencer_if bus ();

  dm_spi_apb_sequencer dut (
    .PCLK        (clk),
    .PRESETN     (rst_n),
    .init_start  (init_start),
    .bus         (bus),
    .init_done   (init_done),
    .busy        (busy),
    .err_slv     (err_slv),
    .err_timeout (err_timeout),
    .frames_sent (frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic wr, input logic [6:0] a, input logic [15:0] d);
    xfer_t t;
    t.wr = wr;
    t.addr = a;
    t.data = d;
    exp_q.push_back(t);
  endtask

  // APB slave model and scoreboard, evaluated on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.M_PREADY  = 1'b0;
      bus.M_PSLVERR = 1'b0;
      bus.M_PRDATA  = 16'h0;
      prev_psel     = 1'b0;
      wcnt          = 0;
      unstable      = 1'b0;
    end else begin
      if (bus.s_ready && (busy || bus.M_PSEL)) sready_bad = 1'b1;
      if (bus.M_PSEL && !bus.M_PENABLE) begin
        check("apb idle gap", {31'd0, prev_psel}, 32'd0);
        su_addr  = bus.M_PADDR;
        su_data  = bus.M_PWDATA;
        su_wr    = bus.M_PWRITE;
        unstable = 1'b0;
        wcnt     = 0;
        bus.M_PREADY  = 1'b0;
        bus.M_PSLVERR = 1'b0;
        if (!bus.M_PWRITE && bus.M_PADDR == REG_STATUS)
          bus.M_PRDATA = (stat_q.size() > 0) ? stat_q[0] : stat_default;
        else
          bus.M_PRDATA = 16'h0;
        if (lat_arm && bus.M_PWRITE &&
            (bus.M_PADDR == REG_TXDATA || bus.M_PADDR == REG_TXDATA_LAST)) begin
          lat_setup = cyc;
          lat_arm   = 1'b0;
        end
      end else if (bus.M_PSEL && bus.M_PENABLE) begin
        if (bus.M_PADDR !== su_addr || bus.M_PWDATA !== su_data || bus.M_PWRITE !== su_wr)
          unstable = 1'b1;
        if (wcnt < wait_cfg) begin
          wcnt++;
          bus.M_PREADY = 1'b0;
        end else begin
          bus.M_PREADY  = 1'b1;
          bus.M_PSLVERR = slverr_arm && bus.M_PWRITE;
          if (slverr_arm && bus.M_PWRITE) slverr_arm = 1'b0;
          if (!bus.M_PWRITE && bus.M_PADDR == REG_STATUS && stat_q.size() > 0)
            void'(stat_q.pop_front());
          xfer_cnt++;
          check("apb stable", {31'd0, unstable}, 32'd0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected xfer: addr %h write %0d data %h, none expected",
                     bus.M_PADDR, bus.M_PWRITE, bus.M_PWDATA);
          end else begin
            xfer_t e;
            e = exp_q.pop_front();
            check("xfer write", {31'd0, bus.M_PWRITE}, {31'd0, e.wr});
            check("xfer addr", {25'd0, bus.M_PADDR}, {25'd0, e.addr});
            if (e.wr) check("xfer wdata", {16'd0, bus.M_PWDATA}, {16'd0, e.data});
          end
        end
      end else begin
        bus.M_PREADY  = 1'b0;
        bus.M_PSLVERR = 1'b0;
      end
      prev_psel = bus.M_PSEL;
    end
  end

  task automatic send_word(input logic [15:0] d, input logic l, output int hs);
    int n;
    n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("s_ready wait", {31'd0, n < 300}, 32'd1);
    @(posedge clk);
    #1;
    hs = cyc;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " completes"}, {31'd0, n < budget}, 32'd1);
  endtask

  initial begin
    int hs1, hs2, base, found;

    vecs[0] = '{16'h1234, 1'b0, 0, REG_TXDATA,      16'd0};
    vecs[1] = '{16'h5678, 1'b0, 0, REG_TXDATA,      16'd0};
    vecs[2] = '{16'h9ABC, 1'b1, 0, REG_TXDATA_LAST, 16'd1};
    vecs[3] = '{16'h0F0F, 1'b0, 4, REG_TXDATA,      16'd1};
    vecs[4] = '{16'hC3C3, 1'b1, 1, REG_TXDATA_LAST, 16'd2};
    vecs[5] = '{16'h0000, 1'b0, 2, REG_TXDATA,      16'd2};

    rst_n       = 1'b0;
    init_start  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'h0;
    bus.s_last  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("reset s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("reset psel", {31'd0, bus.M_PSEL}, 32'd0);
    check("reset penable", {31'd0, bus.M_PENABLE}, 32'd0);
    check("reset init_done", {31'd0, init_done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset frames", {16'd0, frames_sent}, 32'd0);
    check("reset err_slv", {31'd0, err_slv}, 32'd0);
    check("reset err_timeout", {31'd0, err_timeout}, 32'd0);

    // Init sequence: exactly two writes
    base = xfer_cnt;
    exp_push(1'b1, REG_CONTROL, 16'h0003);
    exp_push(1'b1, REG_SSEL, 16'h0001);
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
    wait_idle("init", 200);
    check("init_done", {31'd0, init_done}, 32'd1);
    check("init xfer count", xfer_cnt - base, 32'd2);
    check("ready after init", {31'd0, bus.s_ready}, 32'd1);

    // init_start while READY is ignored
    base = xfer_cnt;
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
    repeat (10) @(negedge clk);
    check("init_start ignored", xfer_cnt - base, 32'd0);
    check("ready kept", {31'd0, bus.s_ready}, 32'd1);

    // Table-driven stream, including TX-full backpressure
    for (int i = 0; i < 6; i++) begin
      sready_bad = 1'b0;
      for (int k = 0; k < vecs[i].n_full; k++) begin
        stat_q.push_back(16'h0008);
        exp_push(1'b0, REG_STATUS, 16'h0);
      end
      stat_q.push_back(16'h0000);
      exp_push(1'b0, REG_STATUS, 16'h0);
      exp_push(1'b1, vecs[i].exp_addr, vecs[i].data);
      send_word(vecs[i].data, vecs[i].last, hs1);
      wait_idle($sformatf("vec%0d", i), 500);
      check($sformatf("vec%0d frames", i), {16'd0, frames_sent}, {16'd0, vecs[i].exp_frames});
      check($sformatf("vec%0d s_ready held low", i), {31'd0, sready_bad}, 32'd0);
    end

    // Latency and throughput with back-to-back words
    exp_push(1'b0, REG_STATUS, 16'h0);
    exp_push(1'b1, REG_TXDATA, 16'hA5A5);
    exp_push(1'b0, REG_STATUS, 16'h0);
    exp_push(1'b1, REG_TXDATA, 16'h5A5A);
    lat_arm = 1'b1;
    send_word(16'hA5A5, 1'b0, hs1);
    send_word(16'h5A5A, 1'b0, hs2);
    wait_idle("b2b", 300);
    check("latency >= 5", {31'd0, (lat_setup - hs1) >= 5}, 32'd1);
    check("throughput >= 6", {31'd0, (hs2 - hs1) >= 6}, 32'd1);
    check("err_slv before", {31'd0, err_slv}, 32'd0);

    // Wait states on every ACCESS plus one PSLVERR on a write
    wait_cfg = 3;
    slverr_arm = 1'b1;
    exp_push(1'b0, REG_STATUS, 16'h0);
    exp_push(1'b1, REG_TXDATA, 16'h1111);
    exp_push(1'b0, REG_STATUS, 16'h0);
    exp_push(1'b1, REG_TXDATA, 16'h2222);
    exp_push(1'b0, REG_STATUS, 16'h0);
    exp_push(1'b1, REG_TXDATA_LAST, 16'h3333);
    send_word(16'h1111, 1'b0, hs1);
    send_word(16'h2222, 1'b0, hs1);
    send_word(16'h3333, 1'b1, hs1);
    wait_idle("wait states", 600);
    check("err_slv set", {31'd0, err_slv}, 32'd1);
    check("frames after ws", {16'd0, frames_sent}, 32'd3);
    check("err_timeout before", {31'd0, err_timeout}, 32'd0);

    // Timeout: STATUS stuck full, word dropped after 1023 reads
    wait_cfg = 0;
    stat_default = 16'h0008;
    for (int k = 0; k < 1023; k++) exp_push(1'b0, REG_STATUS, 16'h0);
    base = xfer_cnt;
    send_word(16'hDEAD, 1'b1, hs1);
    wait_idle("timeout", 8000);
    check("timeout reads", xfer_cnt - base, 32'd1023);
    check("err_timeout set", {31'd0, err_timeout}, 32'd1);
    check("frames after drop", {16'd0, frames_sent}, 32'd3);
    stat_default = 16'h0000;
    exp_push(1'b0, REG_STATUS, 16'h0);
    exp_push(1'b1, REG_TXDATA, 16'hBEEF);
    send_word(16'hBEEF, 1'b0, hs1);
    wait_idle("after timeout", 300);

    // Asynchronous reset in the middle of an ACCESS phase
    wait_cfg = 1000;
    exp_push(1'b0, REG_STATUS, 16'h0);
    send_word(16'h7777, 1'b0, hs1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (bus.M_PSEL && bus.M_PENABLE) found = 1;
    end
    check("reached access", found, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("psel drops at reset", {31'd0, bus.M_PSEL}, 32'd0);
    check("penable drops at reset", {31'd0, bus.M_PENABLE}, 32'd0);
    exp_q.delete();
    stat_q.delete();
    wait_cfg = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-reset busy", {31'd0, busy}, 32'd0);
    check("post-reset s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("post-reset init_done", {31'd0, init_done}, 32'd0);
    check("post-reset frames", {16'd0, frames_sent}, 32'd0);
    check("post-reset err_slv", {31'd0, err_slv}, 32'd0);
    check("post-reset err_timeout", {31'd0, err_timeout}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_spi_apb_sequencer.md
Name: dm_spi_apb_sequencer

Overview:
- APB master that feeds the CoreSPI instance in the DM interface: accepts 16-bit actuator words on a valid/ready stream and turns them into APB register writes on the SPI core.
- Performs one-time core init (CONTROL, SSEL), then per word polls STATUS until the TX FIFO has room and writes TXDATA or TXDATA_LAST (end of DM frame).
- Sits between the DM command buffer (upstream) and the 16-bit-APB, 7-bit-address CoreSPI (downstream).

Parameters:
- APB_AW, 7, APB address width
- APB_DW, 16, APB data width = SPI frame size
- CTRL_INIT, 16'h0003, CONTROL value written at init (enable + master)
- SSEL_INIT, 16'h0001, SSEL value written at init
- TXFULL_BIT, 3, STATUS bit index of TX-FIFO-full
- POLL_LIMIT, 1023, maximum consecutive STATUS reads before a timeout

Ports:
- PCLK  in  1  clock (shared with the SPI core APB)
- PRESETN  in  1  reset, asynchronous, active-low
- init_start  in  1  pulse: run the init sequence
- s_valid  in  1  upstream word valid
- s_ready  out  1  word accepted when s_valid & s_ready
- s_data  in  16  actuator word
- s_last  in  1  last word of DM frame
- M_PADDR  out  7  APB address
- M_PSEL  out  1  APB select
- M_PENABLE  out  1  APB enable
- M_PWRITE  out  1  APB write
- M_PWDATA  out  16  APB write data
- M_PRDATA  in  16  APB read data
- M_PREADY  in  1  APB ready
- M_PSLVERR  in  1  APB slave error
- init_done  out  1  sticky; set after init completes
- busy  out  1  FSM not in IDLE/READY
- err_slv  out  1  sticky; PSLVERR seen
- err_timeout  out  1  sticky; poll limit hit
- frames_sent  out  16  count of TXDATA_LAST writes, wraps

Behaviour:
- Register map (byte offsets): CONTROL 0x00, RXDATA 0x08, TXDATA 0x0C, STATUS 0x20, SSEL 0x24, TXDATA_LAST 0x28.
- Reset: all outputs 0; FSM = IDLE; counters 0.
- APB protocol: SETUP cycle (PSEL=1, PENABLE=0), then ACCESS (PENABLE=1), held until PREADY=1. Address, data and PWRITE are stable across both phases. At least one idle cycle (PSEL=0) between transfers.
- PSLVERR sampled with PREADY: sets err_slv; the sequence continues.
- FSM states and transitions:
  - IDLE: on init_start -> INIT_CTRL. s_ready=0.
  - INIT_CTRL: write CTRL_INIT to CONTROL -> INIT_SSEL.
  - INIT_SSEL: write SSEL_INIT to SSEL -> READY; init_done is set at this transfer's completion.
  - READY: s_ready=1 for one cycle window. On handshake, latch word and last, clear poll count -> POLL.
  - POLL: read STATUS. If STATUS[TXFULL_BIT]=0 -> WRITE. Otherwise increment poll count; at POLL_LIMIT set err_timeout, drop the word -> READY; else repeat POLL.
  - WRITE: write the word to TXDATA, or to TXDATA_LAST if last=1, in which case frames_sent increments at completion -> READY.
- Word latency: handshake to TXDATA SETUP ≥ 5 cycles with zero-wait PREADY.
- Throughput: one word per ≥ 6 cycles.
- s_ready is asserted only in READY, never while a transfer is in flight.
- init_start outside IDLE is ignored.
- Asynchronous reset mid-transfer: PSEL/PENABLE drop immediately; the partial word is lost.

Optional Feature:
- Macro: DM_SPI_SEQ_RXDRAIN_EN.
- Defined: after each TXDATA_LAST write the FSM enters DRAIN. DRAIN reads STATUS; while the rxempty bit (bit 2) is 0 it reads RXDATA and discards the data, then rechecks STATUS. It exits to READY when rxempty=1, or when the POLL_LIMIT total reads are exhausted, in which case err_timeout is set. This prevents RX overflow in master mode.
- Undefined: no DRAIN state; RX data is never read.

Decomposition:
- Shared package dm_spi_pkg holds:
  - register offset constants;
  - the STATUS bit index constants;
  - the FSM state enum;
  - CTRL/SSEL default constants.
- One sub-module: dm_apb_master_xfer. It takes a req/addr/wdata/write command, runs the two-phase APB transfer, and returns a done pulse with rdata and slverr. The sequencer FSM issues commands to it.

Test Plan:
- Init: pulse init_start, PREADY=1 -> writes 0x00←0x0003, then 0x24←0x0001; init_done=1; exactly 2 transfers.
- Stream: three words 0x1234, 0x5678, 0x9ABC (last on the third), STATUS=0x0000 -> reads 0x20; writes 0x0C←0x1234, 0x0C←0x5678, 0x28←0x9ABC; frames_sent=1.
- Backpressure: STATUS=0x0008 for 4 reads, then 0x0000 -> 5 STATUS reads then the TXDATA write; s_ready held 0 throughout.
- Wait states: PREADY low for 3 cycles in each ACCESS phase -> signals held stable, no extra transfers; PSLVERR=1 on one write -> err_slv=1 and the stream still completes.
- Timeout: STATUS stuck at 0x0008 -> after 1023 reads err_timeout=1, the word is dropped, and the next word is accepted.
- Reset: assert PRESETN=0 in an ACCESS phase -> M_PSEL=0 at once; after release FSM=IDLE, init_done=0, frames_sent=0.
